// File: rtl/gpu_pkg.sv
// Shared draw-opcode constants and field layout, used by the assembler and the downstream decoder.
package gpu_pkg;
    localparam int OPCODE_W     = 96;
    localparam int WORD_W       = 16;
    localparam int WORDS_PER_OP = 6;
    localparam int SHAPE_W      = 4;
    localparam int COLOR_W      = 16;
    localparam int COORD_W      = 19;

    localparam int SHAPE_HI = 95;
    localparam int COLOR_HI = 91;
    localparam int C1_HI    = 75;
    localparam int C2_HI    = 56;
    localparam int C3_HI    = 37;
    localparam int C4_HI    = 18;

    localparam int SREG_W = OPCODE_W - WORD_W;
    localparam int CNT_W  = 3;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_OP - 1);

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
    } coord_t;

    typedef struct packed {
        logic [SHAPE_W-1:0] shape;
        logic [COLOR_W-1:0] color;
        coord_t             c1;
        coord_t             c2;
        coord_t             c3;
        coord_t             c4;
    } opcode_t;
endpackage

// File: rtl/opcode_assembler_if.sv
// Word-stream input and opcode output handshake bundle of the opcode assembler.
interface opcode_assembler_if;
    import gpu_pkg::*;

    logic              abort;
    logic [WORD_W-1:0] in_word;
    logic              in_valid;
    logic              in_ready;
    opcode_t           opcode;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              shape_err;

    modport master (
        output abort, in_word, in_valid, out_ready,
        input  in_ready, opcode, out_valid, busy, shape_err
    );

    modport slave (
        input  abort, in_word, in_valid, out_ready,
        output in_ready, opcode, out_valid, busy, shape_err
    );
endinterface

// File: rtl/opcode_assembler_fifo.sv
// Synchronous first-word-fall-through FIFO; head_dat reads as zero while empty.
// Caller must not push when full or pop when empty; push and pop may coincide.
module opcode_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W + 1)'(DEPTH));
    assign head_dat = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/opcode_assembler.sv
// Packs six 16-bit command words (MSB first) into a 96-bit draw opcode, drops illegal shapes,
// and buffers finished opcodes; in_ready only drops on the last word while the buffer is full.
module opcode_assembler
    import gpu_pkg::*;
#(
    parameter logic [15:0] SHAPE_MASK = 16'h07FF,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    opcode_assembler_if.slave bus
);
    logic [CNT_W-1:0]    word_cnt;
    logic [SREG_W-1:0]   sreg;
    logic                legal_q;
    logic                shape_err_q;
    logic                fifo_full;
    logic                fifo_empty;
    logic                last_word;
    logic                accept;
    logic                push;
    logic                pop;
    logic [OPCODE_W-1:0] head_dat;

    assign last_word = (word_cnt == LAST_WORD);
    assign accept    = bus.in_valid && (!last_word || !fifo_full);
    // The final word bypasses the shift register so the opcode is pushed on the cycle it arrives.
    assign push      = accept && last_word && legal_q && !bus.abort;
    assign pop       = !fifo_empty && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt    <= '0;
            sreg        <= '0;
            legal_q     <= 1'b0;
            shape_err_q <= 1'b0;
        end else begin
            shape_err_q <= accept && last_word && !legal_q && !bus.abort;
            if (bus.abort) begin
                word_cnt <= '0;
                legal_q  <= 1'b0;
            end else if (accept) begin
                if (word_cnt == '0) begin
                    legal_q <= SHAPE_MASK[bus.in_word[WORD_W-1 -: SHAPE_W]];
                end
                if (last_word) begin
                    word_cnt <= '0;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                    sreg     <= {sreg[SREG_W-WORD_W-1:0], bus.in_word};
                end
            end
        end
    end

    opcode_fifo #(
        .WIDTH (OPCODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({sreg, bus.in_word}),
        .pop      (pop),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign bus.in_ready  = !last_word || !fifo_full;
    assign bus.opcode    = opcode_t'(head_dat);
    assign bus.out_valid = !fifo_empty;
    assign bus.busy      = (word_cnt != '0);
    assign bus.shape_err = shape_err_q;
endmodule

// File: tb/tb_opcode_assembler.sv
// Directed and randomised stimulus for opcode_assembler with hand-computed expected opcodes.
module tb_opcode_assembler;
    import gpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    opcode_assembler_if tbif();

    opcode_assembler #(
        .SHAPE_MASK (16'h07FF),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (tbif)
    );

    always #5 clk = ~clk;

    // Output monitor: collects popped opcodes, shape_err pulses and head stability while stalled.
    logic [95:0] got_q[$];
    int          err_cnt  = 0;
    int          prot_err = 0;
    logic        prev_stall = 1'b0;
    logic [95:0] prev_op = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!tbif.out_valid || tbif.opcode !== prev_op)) begin
                prot_err++;
                $display("FAIL hold_stable: out_valid=%b opcode=%h required 1 / %h",
                         tbif.out_valid, tbif.opcode, prev_op);
            end
            if (tbif.out_valid && tbif.out_ready) got_q.push_back(tbif.opcode);
            if (tbif.shape_err) err_cnt++;
            prev_stall = tbif.out_valid && !tbif.out_ready;
            prev_op    = tbif.opcode;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w);
        int n = 0;
        tbif.in_word  = w;
        tbif.in_valid = 1'b1;
        while (!tbif.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!tbif.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", tbif.in_ready);
        end
        tick();
        tbif.in_valid = 1'b0;
    endtask

    task automatic send_words(input logic [95:0] op, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send_word(op[95-16*k -: 16]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tbif.abort = 1'b0; tbif.in_valid = 1'b0; tbif.in_word = '0; tbif.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        checks++; if (tbif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", tbif.out_valid); end
        checks++; if (tbif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", tbif.busy); end
        checks++; if (tbif.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", tbif.in_ready); end
        checks++; if (tbif.shape_err !== 1'b0) begin errors++; $display("FAIL rst_shape_err: got %b required 0", tbif.shape_err); end
        checks++; if (tbif.opcode !== 96'h0) begin errors++; $display("FAIL rst_opcode: got %h required 0", tbif.opcode); end
    endtask

    task automatic test_basic();
        logic [95:0] op = 96'hA082_1084_4221_1080_0000_0000;
        int base = got_q.size();
        tbif.out_ready = 1'b1;
        send_words(op, 0, 4);
        checks++; if (tbif.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b required 1", tbif.busy); end
        send_words(op, 5, 5);
        checks++; if (tbif.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid=%b required 1", tbif.out_valid); end
        checks++; if (tbif.opcode !== op) begin errors++; $display("FAIL basic_opcode: got %h required %h", tbif.opcode, op); end
        checks++; if (tbif.opcode.shape !== 4'hA) begin errors++; $display("FAIL basic_shape: got %h required a", tbif.opcode.shape); end
        checks++; if (tbif.opcode.color !== 16'h0821) begin errors++; $display("FAIL basic_color: got %h required 0821", tbif.opcode.color); end
        checks++; if (tbif.opcode.c1 !== 19'b0000100001000100001) begin errors++; $display("FAIL basic_c1: got %b", tbif.opcode.c1); end
        checks++; if (tbif.opcode.c2 !== 19'b0001000010001000010) begin errors++; $display("FAIL basic_c2: got %b", tbif.opcode.c2); end
        checks++; if (tbif.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b required 0", tbif.busy); end
        tick();
        checks++; if (got_q.size() !== base + 1 || got_q[base] !== op) begin errors++; $display("FAIL basic_pop: count %0d required %0d", got_q.size() - base, 1); end
        checks++; if (tbif.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: out_valid=%b required 0", tbif.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [95:0] ops [3] = '{96'h1111_2222_3333_4444_5555_6666,
                                 96'h2AAA_BBBB_CCCC_DDDD_EEEE_FFFF,
                                 96'h3123_4567_89AB_CDEF_0246_8ACE};
        int base = got_q.size();
        tbif.out_ready = 1'b0;
        send_words(ops[0], 0, 5);
        send_words(ops[1], 0, 5);
        send_words(ops[2], 0, 4);
        tbif.in_word = ops[2][15:0]; tbif.in_valid = 1'b1;
        checks++; if (tbif.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall: in_ready=%b required 0", tbif.in_ready); end
        tick();
        checks++; if (tbif.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_hold: in_ready=%b required 0", tbif.in_ready); end
        tbif.out_ready = 1'b1;
        send_word(ops[2][15:0]);
        repeat (6) tick();
        checks++; if (got_q.size() !== base + 3) begin errors++; $display("FAIL b2b_count: got %0d required 3", got_q.size() - base); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q.size() <= base + i || got_q[base+i] !== ops[i]) begin
                errors++; $display("FAIL b2b_order[%0d]: required %h", i, ops[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [95:0] bad  = 96'hF000_1111_2222_3333_4444_5555;
        logic [95:0] good = 96'h5ABC_0123_4567_89AB_CDEF_0F0F;
        int base = got_q.size();
        int e0 = err_cnt;
        tbif.out_ready = 1'b1;
        send_words(bad, 0, 5);
        checks++; if (tbif.shape_err !== 1'b1) begin errors++; $display("FAIL illegal_pulse: shape_err=%b required 1", tbif.shape_err); end
        checks++; if (tbif.out_valid !== 1'b0) begin errors++; $display("FAIL illegal_no_push: out_valid=%b required 0", tbif.out_valid); end
        tick();
        checks++; if (tbif.shape_err !== 1'b0) begin errors++; $display("FAIL illegal_pulse_end: shape_err=%b required 0", tbif.shape_err); end
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL illegal_pulse_count: got %0d required 1", err_cnt - e0); end
        send_words(good, 0, 5);
        tick();
        checks++; if (got_q.size() !== base + 1 || got_q[base] !== good) begin errors++; $display("FAIL illegal_next: count %0d required 1 with %h", got_q.size() - base, good); end
    endtask

    task automatic test_pop_push();
        logic [95:0] ops [4] = '{96'h0E0E_1010_2020_3030_4040_5050,
                                 96'h4F0F_6060_7070_8080_9090_A0A0,
                                 96'h6777_B0B0_C0C0_D0D0_E0E0_F0F0,
                                 96'h9888_0101_0202_0303_0404_0505};
        int base = got_q.size();
        tbif.out_ready = 1'b0;
        send_words(ops[0], 0, 5);
        send_words(ops[1], 0, 5);
        send_words(ops[2], 0, 4);
        tbif.in_word = ops[2][15:0]; tbif.in_valid = 1'b1; tbif.out_ready = 1'b1;
        checks++; if (tbif.in_ready !== 1'b0) begin errors++; $display("FAIL pp_full: in_ready=%b required 0", tbif.in_ready); end
        tick();
        tbif.out_ready = 1'b0;
        checks++; if (tbif.in_ready !== 1'b1) begin errors++; $display("FAIL pp_after_pop: in_ready=%b required 1", tbif.in_ready); end
        tick();
        tbif.in_valid = 1'b0;
        checks++; if (tbif.busy !== 1'b0) begin errors++; $display("FAIL pp_pushed: busy=%b required 0", tbif.busy); end
        send_words(ops[3], 0, 4);
        tbif.in_word = ops[3][15:0]; tbif.in_valid = 1'b1;
        checks++; if (tbif.in_ready !== 1'b0) begin errors++; $display("FAIL pp_count_two: in_ready=%b required 0", tbif.in_ready); end
        tbif.out_ready = 1'b1;
        send_word(ops[3][15:0]);
        repeat (8) tick();
        checks++; if (got_q.size() !== base + 4) begin errors++; $display("FAIL pp_count: got %0d required 4", got_q.size() - base); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q.size() <= base + i || got_q[base+i] !== ops[i]) begin
                errors++; $display("FAIL pp_order[%0d]: required %h", i, ops[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [95:0] part = 96'h2DEAD_BEEF_0000_0000_0000_000 >> 4;
        logic [95:0] full = 96'h7C0D_E123_4567_0ACE_1357_9BDF;
        int base = got_q.size();
        int e0 = err_cnt;
        tbif.out_ready = 1'b1;
        send_words(part, 0, 2);
        tbif.abort = 1'b1; tbif.in_word = 16'hFFFF; tbif.in_valid = 1'b1;
        tick();
        tbif.abort = 1'b0; tbif.in_valid = 1'b0;
        checks++; if (tbif.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", tbif.busy); end
        send_words(full, 0, 5);
        tick();
        checks++; if (got_q.size() !== base + 1 || got_q[base] !== full) begin errors++; $display("FAIL abort_next: count %0d required 1 with %h", got_q.size() - base, full); end
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL abort_no_err: pulses %0d required 0", err_cnt - e0); end
    endtask

    task automatic test_reset_mid();
        logic [95:0] buffered = 96'h1555_6666_7777_8888_9999_AAAA;
        logic [95:0] fresh    = 96'h8246_1357_9BDF_0246_8ACE_1234;
        int base;
        tbif.out_ready = 1'b0;
        send_words(buffered, 0, 5);
        checks++; if (tbif.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_buffered: out_valid=%b required 1", tbif.out_valid); end
        send_words(fresh, 0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (tbif.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b required 0", tbif.out_valid); end
        checks++; if (tbif.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b required 0", tbif.busy); end
        checks++; if (tbif.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b required 1", tbif.in_ready); end
        base = got_q.size();
        tbif.out_ready = 1'b1;
        send_words(fresh, 0, 5);
        tick();
        checks++; if (got_q.size() !== base + 1 || got_q[base] !== fresh) begin errors++; $display("FAIL rmid_fresh: count %0d required 1 with %h", got_q.size() - base, fresh); end
    endtask

    task automatic test_stress();
        localparam int N = 24;
        logic [95:0] exp_ops [N];
        logic [15:0] words [N*6];
        int base = got_q.size();
        int idx = 0;
        int cyc = 0;
        logic acc;
        for (int i = 0; i < N; i++) begin
            exp_ops[i] = {$urandom, $urandom, $urandom};
            exp_ops[i][95:92] = 4'($urandom_range(0, 10));
            for (int k = 0; k < 6; k++) words[i*6+k] = exp_ops[i][95-16*k -: 16];
        end
        while (idx < N*6 && cyc < 5000) begin
            tbif.out_ready = 1'($urandom_range(0, 1));
            if (!tbif.in_valid && $urandom_range(0, 2) != 0) begin
                tbif.in_valid = 1'b1;
                tbif.in_word  = words[idx];
            end
            @(negedge clk);
            acc = tbif.in_valid && tbif.in_ready;
            tick();
            if (acc) begin
                idx++;
                tbif.in_valid = 1'b0;
            end
            cyc++;
        end
        tbif.in_valid = 1'b0;
        checks++; if (idx !== N*6) begin errors++; $display("FAIL stress_timeout: words %0d required %0d", idx, N*6); end
        tbif.out_ready = 1'b1;
        repeat (10) tick();
        checks++; if (got_q.size() !== base + N) begin errors++; $display("FAIL stress_count: got %0d required %0d", got_q.size() - base, N); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got_q.size() <= base + i || got_q[base+i] !== exp_ops[i]) begin
                errors++; $display("FAIL stress_op[%0d]: required %h", i, exp_ops[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_pop_push();
        test_abort();
        test_reset_mid();
        test_stress();
        checks++; if (prot_err !== 0) begin errors++; $display("FAIL protocol_total: got %0d required 0", prot_err); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
